// File: rtl/gpio_rx_conditioner_pkg.sv
// gpio_pkg
// Shared constants, types and helpers for the GPIO receive-side conditioner.
// Contents:
//   DEBOUNCE_DEFAULT    default number of stable synchronized cycles to accept a level
//   GPIO_WIDTH_DEFAULT  default number of GPIO input channels
//   cnt_width(n)        width of a counter able to hold the value n
//   edge_mode_t         register-side encoding of {fallEn, riseEn} per channel

package gpio_pkg;

   localparam int unsigned DEBOUNCE_DEFAULT   = 16;
   localparam int unsigned GPIO_WIDTH_DEFAULT = 4;

   // {fallEn, riseEn} packed into two bits gives exactly this ordering.
   typedef enum logic [1:0] {
      EDGE_NONE = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_mode_t;

   // The counter never reaches n, but sizing for n keeps n=1 at one bit wide.
   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/gpio_debounce_ch.sv
// gpio_debounce_ch
// One GPIO input channel: 2-FF synchronizer, counter debouncer and
// rising/falling edge detector.
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   dataRx_i     raw pad input, asynchronous to clk
//   level_o      debounced, synchronized level
//   risePulse_o  one-cycle pulse in the first cycle level_o shows 1
//   fallPulse_o  one-cycle pulse in the first cycle level_o shows 0

module gpio_debounce_ch
   import gpio_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter logic        RESET_LEVEL     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic dataRx_i,
   output logic level_o,
   output logic risePulse_o,
   output logic fallPulse_o
);

   localparam int unsigned      CNT_W   = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1Q;
   logic             sync2Q;
   logic [CNT_W-1:0] cntQ;
   logic [CNT_W-1:0] cntD;
   logic             levelQ;
   logic             levelD;
   logic             riseQ;
   logic             riseD;
   logic             fallQ;
   logic             fallD;

   // Two-flop synchronizer; only sync2Q is allowed to reach the debouncer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1Q <= RESET_LEVEL;
         sync2Q <= RESET_LEVEL;
      end else begin
         sync1Q <= dataRx_i;
         sync2Q <= sync1Q;
      end
   end

   // Count consecutive cycles where the synchronized input disagrees with
   // the accepted level. Any agreement restarts the count, so only an
   // unbroken run of DEBOUNCE_CYCLES mismatches moves the level. The edge
   // pulses are produced on the same transition so they line up with the
   // first cycle showing the new level.
   always_comb begin
      cntD   = cntQ;
      levelD = levelQ;
      riseD  = 1'b0;
      fallD  = 1'b0;
      if (sync2Q == levelQ) begin
         cntD = '0;
      end else if (cntQ == CNT_MAX) begin
         cntD   = '0;
         levelD = sync2Q;
         riseD  = sync2Q;
         fallD  = ~sync2Q;
      end else begin
         cntD = cntQ + CNT_W'(1);
      end
   end

   // Debounce and edge state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cntQ   <= '0;
         levelQ <= RESET_LEVEL;
         riseQ  <= 1'b0;
         fallQ  <= 1'b0;
      end else begin
         cntQ   <= cntD;
         levelQ <= levelD;
         riseQ  <= riseD;
         fallQ  <= fallD;
      end
   end

   assign level_o     = levelQ;
   assign risePulse_o = riseQ;
   assign fallPulse_o = fallQ;

endmodule

// File: rtl/gpio_rx_conditioner.sv
// gpio_rx_conditioner
// Receive-side conditioning for GPIO pad inputs: per-channel synchronizer,
// debouncer and edge detector, plus sticky write-1-to-clear event flags and
// an aggregate interrupt.
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   dataRx        raw pad inputs, asynchronous to clk
//   riseEn        per-channel enable for latching rising-edge events
//   fallEn        per-channel enable for latching falling-edge events
//   eventClr      write-1-to-clear strobe for eventPending
//   level         debounced, synchronized pin levels
//   risePulse     one-cycle pulse per channel on a 0->1 level change
//   fallPulse     one-cycle pulse per channel on a 1->0 level change
//   eventPending  sticky per-channel event flags
//   irq           OR of all eventPending flags

module gpio_rx_conditioner
   import gpio_pkg::*;
#(
   parameter int unsigned WIDTH           = GPIO_WIDTH_DEFAULT,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter logic        RESET_LEVEL     = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] dataRx,
   input  logic [WIDTH-1:0] riseEn,
   input  logic [WIDTH-1:0] fallEn,
   input  logic [WIDTH-1:0] eventClr,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] risePulse,
   output logic [WIDTH-1:0] fallPulse,
   output logic [WIDTH-1:0] eventPending,
   output logic             irq
);

   logic [WIDTH-1:0] eventSet;
   logic [WIDTH-1:0] eventPendingQ;
   logic [WIDTH-1:0] eventPendingD;

   // One independent conditioning chain per pin.
   for (genvar i = 0; i < WIDTH; i++) begin : gChannel
      gpio_debounce_ch #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .RESET_LEVEL    (RESET_LEVEL)
      ) uChannel (
         .clk        (clk),
         .rst_n      (rst_n),
         .dataRx_i   (dataRx[i]),
         .level_o    (level[i]),
         .risePulse_o(risePulse[i]),
         .fallPulse_o(fallPulse[i])
      );
   end

   // A qualified edge sets the flag; the clear strobe only removes flags
   // that are not being set in the same cycle, so an event is never lost.
   always_comb begin
      eventSet      = (risePulse & riseEn) | (fallPulse & fallEn);
      eventPendingD = eventSet | (eventPendingQ & ~eventClr);
   end

   // Sticky event flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eventPendingQ <= '0;
      end else begin
         eventPendingQ <= eventPendingD;
      end
   end

   assign eventPending = eventPendingQ;
   assign irq          = |eventPendingQ;

endmodule

// File: tb/tb_gpio_rx_conditioner.sv
// tb_gpio_rx_conditioner
// Directed bench for gpio_rx_conditioner with DEBOUNCE_CYCLES=4, WIDTH=4,
// RESET_LEVEL=0. Edge pulses are scored against a queue of expected pulses
// (cycle, rise, fall, new level); steady-state outputs are compared directly.

module tb_gpio_rx_conditioner;

   localparam int unsigned DEB     = 4;
   localparam int          LATENCY = DEB + 2;

   typedef struct {
      int         cyc;
      logic [3:0] rise;
      logic [3:0] fall;
      logic [3:0] lvl;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] dataRx;
   logic [3:0] riseEn;
   logic [3:0] fallEn;
   logic [3:0] eventClr;
   logic [3:0] level;
   logic [3:0] risePulse;
   logic [3:0] fallPulse;
   logic [3:0] eventPending;
   logic       irq;

   int   cycleCnt   = 0;
   int   checkCount = 0;
   int   failCount  = 0;
   exp_t expQ[$];

   gpio_rx_conditioner #(
      .WIDTH          (4),
      .DEBOUNCE_CYCLES(DEB),
      .RESET_LEVEL    (1'b0)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .dataRx      (dataRx),
      .riseEn      (riseEn),
      .fallEn      (fallEn),
      .eventClr    (eventClr),
      .level       (level),
      .risePulse   (risePulse),
      .fallPulse   (fallPulse),
      .eventPending(eventPending),
      .irq         (irq)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count rising edges so expected pulses can be tied to an exact cycle.
   always @(posedge clk) cycleCnt++;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycleCnt);
      end
   endtask

   // Advance n edges, then settle 2 ns past the last one.
   task automatic waitEdges(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic [3:0] data, input logic [3:0] rEn, input logic [3:0] fEn);
      dataRx = data;
      riseEn = rEn;
      fallEn = fEn;
   endtask

   // A pad change made now shows up as a level change LATENCY edges later.
   task automatic expectPulse(input logic [3:0] rise, input logic [3:0] fall, input logic [3:0] lvl);
      exp_t e;
      e.cyc  = cycleCnt + LATENCY;
      e.rise = rise;
      e.fall = fall;
      e.lvl  = lvl;
      expQ.push_back(e);
   endtask

   // Monitor: every cycle presenting a pulse must match the oldest expected
   // pulse; an expected pulse whose cycle has passed was missed.
   always @(negedge clk) begin
      if (expQ.size() > 0 && expQ[0].cyc < cycleCnt) begin
         checkCount++;
         failCount++;
         $display("[TB] FAIL missingPulse: pulse expected at cycle %0d did not occur (now %0d)", expQ[0].cyc, cycleCnt);
         void'(expQ.pop_front());
      end
      if (rst_n && (risePulse != 4'h0 || fallPulse != 4'h0)) begin
         if (expQ.size() == 0) begin
            checkCount++;
            failCount++;
            $display("[TB] FAIL unexpectedPulse: rise=0x%0h fall=0x%0h expected none (cycle %0d)", risePulse, fallPulse, cycleCnt);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("pulseCycle", cycleCnt, e.cyc);
            checkOutput("risePulse", {28'd0, risePulse}, {28'd0, e.rise});
            checkOutput("fallPulse", {28'd0, fallPulse}, {28'd0, e.fall});
            checkOutput("levelAtPulse", {28'd0, level}, {28'd0, e.lvl});
         end
      end
   end

   initial begin
      rst_n    = 1'b0;
      eventClr = 4'h0;
      applyStimulus(4'hF, 4'h0, 4'h0);

      // 1. Reset with all pads high, then release.
      waitEdges(3);
      checkOutput("resetLevel", {28'd0, level}, 32'h0);
      checkOutput("resetEvent", {28'd0, eventPending}, 32'h0);
      checkOutput("resetIrq", {31'd0, irq}, 32'h0);
      checkOutput("resetRise", {28'd0, risePulse}, 32'h0);
      rst_n = 1'b1;
      expectPulse(4'hF, 4'h0, 4'hF);
      waitEdges(LATENCY - 1);
      checkOutput("levelBeforeRelease6", {28'd0, level}, 32'h0);
      waitEdges(1);
      checkOutput("levelAfterRelease6", {28'd0, level}, 32'hF);
      waitEdges(2);

      // Bring every channel back low with no edge enables.
      applyStimulus(4'h0, 4'h0, 4'h0);
      expectPulse(4'h0, 4'hF, 4'h0);
      waitEdges(LATENCY + 2);
      checkOutput("allFallEvent", {28'd0, eventPending}, 32'h0);

      // 2. Clean rise on ch0 with riseEn[0].
      applyStimulus(4'h1, 4'h1, 4'h0);
      expectPulse(4'h1, 4'h0, 4'h1);
      waitEdges(LATENCY + 1);
      checkOutput("ch0RiseEvent", {28'd0, eventPending}, 32'h1);
      checkOutput("ch0RiseIrq", {31'd0, irq}, 32'h1);
      eventClr = 4'h1;
      waitEdges(1);
      eventClr = 4'h0;
      checkOutput("ch0ClearEvent", {28'd0, eventPending}, 32'h0);
      checkOutput("ch0ClearIrq", {31'd0, irq}, 32'h0);

      // 3. Three-cycle glitch on ch1 must be rejected.
      applyStimulus(4'h3, 4'h1, 4'h0);
      waitEdges(3);
      applyStimulus(4'h1, 4'h1, 4'h0);
      waitEdges(10);
      checkOutput("glitchLevel", {28'd0, level}, 32'h1);
      checkOutput("glitchEvent", {28'd0, eventPending}, 32'h0);

      // 4. Raise ch2 unqualified, then fall with only riseEn[2] set.
      applyStimulus(4'h5, 4'h1, 4'h0);
      expectPulse(4'h4, 4'h0, 4'h5);
      waitEdges(LATENCY + 2);
      checkOutput("ch2RiseNoEvent", {28'd0, eventPending}, 32'h0);
      applyStimulus(4'h1, 4'h5, 4'h0);
      expectPulse(4'h0, 4'h4, 4'h1);
      waitEdges(LATENCY + 2);
      checkOutput("ch2FallEvent", {28'd0, eventPending}, 32'h0);
      checkOutput("ch2FallIrq", {31'd0, irq}, 32'h0);
      checkOutput("ch2FallLevel", {28'd0, level}, 32'h1);

      // 5. Clear coincident with a qualified rise on ch0: set must win.
      applyStimulus(4'h0, 4'h0, 4'h0);
      expectPulse(4'h0, 4'h1, 4'h0);
      waitEdges(LATENCY + 2);
      applyStimulus(4'h1, 4'h1, 4'h0);
      expectPulse(4'h1, 4'h0, 4'h1);
      waitEdges(LATENCY);
      eventClr = 4'h1;
      waitEdges(1);
      eventClr = 4'h0;
      checkOutput("setWinsEvent", {28'd0, eventPending}, 32'h1);
      checkOutput("setWinsIrq", {31'd0, irq}, 32'h1);
      waitEdges(2);
      eventClr = 4'h1;
      waitEdges(1);
      eventClr = 4'h0;
      checkOutput("loneClearEvent", {28'd0, eventPending}, 32'h0);
      checkOutput("loneClearIrq", {31'd0, irq}, 32'h0);

      // 6. Reset in the middle of a ch3 debounce.
      applyStimulus(4'h9, 4'h0, 4'h0);
      waitEdges(3);
      rst_n = 1'b0;
      #1;
      checkOutput("midResetLevel", {28'd0, level}, 32'h0);
      checkOutput("midResetRise", {28'd0, risePulse}, 32'h0);
      checkOutput("midResetFall", {28'd0, fallPulse}, 32'h0);
      checkOutput("midResetEvent", {28'd0, eventPending}, 32'h0);
      checkOutput("midResetIrq", {31'd0, irq}, 32'h0);
      waitEdges(2);
      rst_n = 1'b1;
      expectPulse(4'h9, 4'h0, 4'h9);
      waitEdges(LATENCY - 1);
      checkOutput("postResetLevel5", {28'd0, level}, 32'h0);
      waitEdges(1);
      checkOutput("postResetLevel6", {28'd0, level}, 32'h9);
      waitEdges(4);

      checkOutput("pulseQueueEmpty", expQ.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
